// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor conditioner: state encoding and glitch-counter sizing.
// Downstream FSMs and benches import this to decode the debug state.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } cond_state_e;

    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    // Saturating increment so the glitch count sticks at its maximum.
    function automatic logic [GLITCH_W-1:0] glitch_inc(input logic [GLITCH_W-1:0] v);
        return (v == GLITCH_MAX) ? v : v + GLITCH_W'(1);
    endfunction

endpackage

// File: rtl/sensor_conditioner_sync_chain.sv
// Multi-flop synchronizer; the only point where the asynchronous sensor line enters the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces the raw sensor line into a clean level with rise/fall strobes,
// counting short pulses that revert before the debounce window completes.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sensor_raw,
    output logic                a,
    output logic                rise,
    output logic                fall,
    output logic [1:0]          st,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic                s;
    cond_state_e         state_q;
    logic                a_q;
    logic                rise_q;
    logic                fall_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [GLITCH_W-1:0] glitch_q;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sensor_raw),
        .q    (s)
    );

    // cnt counts cycles the new level has already held; commit on the DEBOUNCE-th matching sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE_LO;
            a_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            glitch_q <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LO: begin
                    if (s != a_q) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (s != a_q) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (s) begin
                        if (cnt_q == CNT_LAST) begin
                            a_q     <= 1'b1;
                            rise_q  <= 1'b1;
                            state_q <= IDLE_HI;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_q  <= IDLE_LO;
                        cnt_q    <= '0;
                        glitch_q <= glitch_inc(glitch_q);
                    end
                end
                WAIT_LO: begin
                    if (!s) begin
                        if (cnt_q == CNT_LAST) begin
                            a_q     <= 1'b0;
                            fall_q  <= 1'b1;
                            state_q <= IDLE_LO;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_q  <= IDLE_HI;
                        cnt_q    <= '0;
                        glitch_q <= glitch_inc(glitch_q);
                    end
                end
                default: begin
                    state_q <= IDLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign a          = a_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign st         = state_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: pulse-length table plus reset, pattern, saturation and mid-WAIT sequences.
module tb_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_raw;
    logic       a;
    logic       rise;
    logic       fall;
    logic [1:0] st;
    logic [7:0] glitch_cnt;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    int rise_tot  = 0;
    int fall_tot  = 0;
    int last_rise = -1;
    int last_fall = -1;
    int both_hi   = 0;
    int strobe_bad = 0;

    typedef struct {
        int len;
        int exp_rise;
        int exp_fall;
        int exp_glitch;
        int exp_a;
    } vec_t;

    vec_t vecs[5];

    sensor_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_raw(sensor_raw),
        .a         (a),
        .rise      (rise),
        .fall      (fall),
        .st        (st),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rise === 1'b1) begin
            rise_tot++;
            last_rise = cyc;
            if (a !== 1'b1) strobe_bad++;
        end
        if (fall === 1'b1) begin
            fall_tot++;
            last_fall = cyc;
            if (a !== 1'b0) strobe_bad++;
        end
        if (rise === 1'b1 && fall === 1'b1) both_hi++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        sensor_raw = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cap;
        int drop;
        int rb;
        int fb;
        int pat[15];

        vecs[0] = '{len: 1,  exp_rise: 0, exp_fall: 0, exp_glitch: 1, exp_a: 0};
        vecs[1] = '{len: 2,  exp_rise: 0, exp_fall: 0, exp_glitch: 1, exp_a: 0};
        vecs[2] = '{len: 3,  exp_rise: 0, exp_fall: 0, exp_glitch: 1, exp_a: 0};
        vecs[3] = '{len: 4,  exp_rise: 1, exp_fall: 1, exp_glitch: 0, exp_a: 0};
        vecs[4] = '{len: 10, exp_rise: 1, exp_fall: 1, exp_glitch: 0, exp_a: 0};
        pat = '{1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0};

        // Reset held two cycles with the raw line high, then a normal full-latency rise.
        reset      = 1'b1;
        sensor_raw = 1'b1;
        @(negedge clk);
        chk("rst_a", a, 0);
        chk("rst_st", st, 0);
        chk("rst_glitch", glitch_cnt, 0);
        @(negedge clk);
        chk("rst_rise", rise, 0);
        rb    = rise_tot;
        reset = 1'b0;
        cap   = cyc + 1;
        repeat (10) @(negedge clk);
        chk("rst_rel_rise_cnt", rise_tot - rb, 1);
        chk("rst_rel_rise_lat", last_rise - cap, 5);
        chk("rst_rel_a", a, 1);

        // Pulse-length table.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            rb  = rise_tot;
            fb  = fall_tot;
            cap = cyc + 1;
            sensor_raw = 1'b1;
            repeat (vecs[i].len) @(negedge clk);
            drop = cyc + 1;
            sensor_raw = 1'b0;
            repeat (14) @(negedge clk);
            chk($sformatf("len%0d_rise", vecs[i].len), rise_tot - rb, vecs[i].exp_rise);
            chk($sformatf("len%0d_fall", vecs[i].len), fall_tot - fb, vecs[i].exp_fall);
            chk($sformatf("len%0d_glitch", vecs[i].len), glitch_cnt, vecs[i].exp_glitch);
            chk($sformatf("len%0d_a", vecs[i].len), a, vecs[i].exp_a);
            chk($sformatf("len%0d_st", vecs[i].len), st, 0);
            if (vecs[i].exp_rise != 0) begin
                chk($sformatf("len%0d_rise_lat", vecs[i].len), last_rise - cap, 5);
                chk($sformatf("len%0d_fall_lat", vecs[i].len), last_fall - drop, 5);
            end
        end

        // Bit pattern: runs of 1 are at most two cycles, so five reverted runs.
        do_reset();
        rb = rise_tot;
        for (int i = 0; i < 15; i++) begin
            sensor_raw = pat[i][0];
            @(negedge clk);
        end
        sensor_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("pat_rise", rise_tot - rb, 0);
        chk("pat_a", a, 0);
        chk("pat_glitch", glitch_cnt, 5);

        // Saturation of the glitch counter.
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            sensor_raw = 1'b1;
            repeat (3) @(negedge clk);
            sensor_raw = 1'b0;
            repeat (3) @(negedge clk);
            if (i == 254) chk("sat_254", glitch_cnt, 254);
            if (i == 255) chk("sat_255", glitch_cnt, 255);
        end
        repeat (4) @(negedge clk);
        chk("sat_300", glitch_cnt, 255);

        // Reset while WAIT_HI with cnt = 2.
        do_reset();
        sensor_raw = 1'b1;
        repeat (4) @(negedge clk);
        chk("midwait_st_before", st, 1);
        rb         = rise_tot;
        reset      = 1'b1;
        sensor_raw = 1'b0;
        @(negedge clk);
        chk("midwait_st", st, 0);
        chk("midwait_a", a, 0);
        chk("midwait_glitch", glitch_cnt, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("midwait_rise", rise_tot - rb, 0);
        chk("midwait_glitch_after", glitch_cnt, 0);

        chk("strobes_both_high", both_hi, 0);
        chk("strobe_vs_a", strobe_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
